// File: rtl/branch_predictor_table_pkg.sv
// Shared definitions for the fetch-stage branch direction predictor table.
//
// Holds the default table geometry, the derived index width, the counter
// reset value and the taken/not-taken direction encoding. The multi-entry
// table is addressed by W_IDX bits, so a single fixed branch-id width is no
// longer needed.
package branch_predictor_table_pkg;

    localparam int BPT_W_PC    = 32;
    localparam int BPT_W_CNT   = 2;
    localparam int BPT_N_ENTRY = 64;
    localparam int BPT_W_HIST  = 6;
    localparam int BPT_GSHARE  = 1;
    localparam int BPT_W_IDX   = $clog2(BPT_N_ENTRY);

    // Direction of a resolved or predicted branch.
    typedef enum logic {
        DIR_NOT_TAKEN = 1'b0,
        DIR_TAKEN     = 1'b1
    } branch_dir_e;

    // Weakly-not-taken counter value: MSB clear, all lower bits set.
    function automatic int cnt_reset_value(input int w_cnt);
        return (1 << (w_cnt - 1)) - 1;
    endfunction

    localparam logic [BPT_W_CNT-1:0] BPT_CNT_RESET = BPT_W_CNT'(cnt_reset_value(BPT_W_CNT));

endpackage

// File: rtl/branch_predictor_table_sat_counter_next.sv
// Combinational next-state function of one saturating direction counter.
//
// Ports:
//   cnt_i   - current counter value
//   taken_i - resolved direction (1 = taken: count up, 0 = not taken: count down)
//   cnt_o   - next counter value, held at all-ones / zero instead of wrapping
module sat_counter_next
    import branch_predictor_table_pkg::*;
#(
    parameter int W_CNT = BPT_W_CNT
) (
    input  logic [W_CNT-1:0] cnt_i,
    input  logic             taken_i,
    output logic [W_CNT-1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (branch_dir_e'(taken_i) == DIR_TAKEN) begin
            if (!(&cnt_i)) begin
                cnt_o = cnt_i + W_CNT'(1);
            end
        end else begin
            if (|cnt_i) begin
                cnt_o = cnt_i - W_CNT'(1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor_table.sv
// Table of saturating branch-direction counters for the fetch stage.
//
// A lookup indexes the table with PC[W_IDX+1:2], optionally XORed with the
// global history (gshare), and presents the counter one cycle later. The
// execute stage trains counters through the update port using the index that
// travelled with the branch; in gshare mode the resolved outcome is shifted
// into the history on the same edge.
//
// Ports:
//   clk, reset      - clock; asynchronous active-low reset
//   lookup_v_i      - lookup request this cycle
//   lookup_pc_i     - fetch PC
//   pred_v_o        - registered lookup valid
//   pred_taken_o    - predicted direction (counter MSB)
//   pred_idx_o      - table index used by the lookup
//   pred_cnt_o      - counter value read
//   update_v_i      - resolved-branch update
//   update_idx_i    - index returned from pred_idx_o
//   update_taken_i  - actual outcome
//   hist_o          - current global history
module branch_predictor_table
    import branch_predictor_table_pkg::*;
#(
    parameter  int W_PC    = BPT_W_PC,
    parameter  int W_CNT   = BPT_W_CNT,
    parameter  int N_ENTRY = BPT_N_ENTRY,
    parameter  int W_HIST  = BPT_W_HIST,
    parameter  int GSHARE  = BPT_GSHARE,
    localparam int W_IDX   = $clog2(N_ENTRY)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_v_i,
    input  logic [W_PC-1:0]   lookup_pc_i,
    output logic              pred_v_o,
    output logic              pred_taken_o,
    output logic [W_IDX-1:0]  pred_idx_o,
    output logic [W_CNT-1:0]  pred_cnt_o,
    input  logic              update_v_i,
    input  logic [W_IDX-1:0]  update_idx_i,
    input  logic              update_taken_i,
    output logic [W_HIST-1:0] hist_o
);

    localparam logic [W_CNT-1:0] CNT_RST = W_CNT'(cnt_reset_value(W_CNT));

    logic [W_CNT-1:0]  cnt_q [N_ENTRY];
    logic [W_CNT-1:0]  cnt_d [N_ENTRY];
    logic [W_HIST-1:0] hist_q, hist_d;
    logic              pred_v_q, pred_v_d;
    logic              pred_taken_q, pred_taken_d;
    logic [W_IDX-1:0]  pred_idx_q, pred_idx_d;
    logic [W_CNT-1:0]  pred_cnt_q, pred_cnt_d;

    logic [W_IDX-1:0]  lookup_idx;
    logic [W_CNT-1:0]  upd_next;
    logic [W_CNT-1:0]  rd_cnt;

    // Only PC[W_IDX+1:2] addresses the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i[W_PC-1:W_IDX+2], lookup_pc_i[1:0]};

    sat_counter_next #(
        .W_CNT (W_CNT)
    ) u_sat_counter_next (
        .cnt_i   (cnt_q[update_idx_i]),
        .taken_i (update_taken_i),
        .cnt_o   (upd_next)
    );

    // The lookup hashes with the history as it stands this cycle, before any
    // same-cycle update shifts it. A same-index update is forwarded so the
    // prediction never shows a counter that is already stale.
    always_comb begin
        lookup_idx = lookup_pc_i[W_IDX+1:2];
        if (GSHARE != 0) begin
            lookup_idx = lookup_pc_i[W_IDX+1:2] ^ W_IDX'(hist_q);
        end

        rd_cnt = cnt_q[lookup_idx];
        if (update_v_i && (update_idx_i == lookup_idx)) begin
            rd_cnt = upd_next;
        end

        pred_v_d     = lookup_v_i;
        pred_taken_d = pred_taken_q;
        pred_idx_d   = pred_idx_q;
        pred_cnt_d   = pred_cnt_q;
        if (lookup_v_i) begin
            pred_taken_d = rd_cnt[W_CNT-1];
            pred_idx_d   = lookup_idx;
            pred_cnt_d   = rd_cnt;
        end
    end

    // Training path; history is only advanced by resolved branches, so it
    // never needs repair after a misprediction.
    always_comb begin
        cnt_d  = cnt_q;
        hist_d = hist_q;
        if (update_v_i) begin
            cnt_d[update_idx_i] = upd_next;
            if (GSHARE != 0) begin
                hist_d = W_HIST'({hist_q, update_taken_i});
            end
        end
        if (GSHARE == 0) begin
            hist_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ENTRY; i++) begin
                cnt_q[i] <= CNT_RST;
            end
            hist_q       <= '0;
            pred_v_q     <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
            pred_cnt_q   <= CNT_RST;
        end else begin
            cnt_q        <= cnt_d;
            hist_q       <= hist_d;
            pred_v_q     <= pred_v_d;
            pred_taken_q <= pred_taken_d;
            pred_idx_q   <= pred_idx_d;
            pred_cnt_q   <= pred_cnt_d;
        end
    end

    assign pred_v_o     = pred_v_q;
    assign pred_taken_o = pred_taken_q;
    assign pred_idx_o   = pred_idx_q;
    assign pred_cnt_o   = pred_cnt_q;
    assign hist_o       = hist_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Testbench for branch_predictor_table.
//
// Three instances share one stimulus stream: gshare with 2-bit counters,
// bimodal with 2-bit counters and bimodal with 3-bit counters. A behavioural
// model predicts each lookup result when the lookup is driven and queues it;
// the queued entry is compared when the registered prediction appears.
module tb_branch_predictor_table;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lookup_v = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        update_v = 1'b0;
    logic [5:0]  update_idx = '0;
    logic        update_taken = 1'b0;

    logic       gs_pred_v, gs_pred_taken;
    logic [5:0] gs_pred_idx, gs_hist;
    logic [1:0] gs_pred_cnt;
    logic       bi_pred_v, bi_pred_taken;
    logic [5:0] bi_pred_idx, bi_hist;
    logic [1:0] bi_pred_cnt;
    logic       b3_pred_v, b3_pred_taken;
    logic [5:0] b3_pred_idx, b3_hist;
    logic [2:0] b3_pred_cnt;

    always #5 clk = ~clk;

    branch_predictor_table #(.GSHARE(1), .W_CNT(2)) u_gs (
        .clk(clk), .reset(reset),
        .lookup_v_i(lookup_v), .lookup_pc_i(lookup_pc),
        .pred_v_o(gs_pred_v), .pred_taken_o(gs_pred_taken),
        .pred_idx_o(gs_pred_idx), .pred_cnt_o(gs_pred_cnt),
        .update_v_i(update_v), .update_idx_i(update_idx),
        .update_taken_i(update_taken), .hist_o(gs_hist)
    );

    branch_predictor_table #(.GSHARE(0), .W_CNT(2)) u_bi (
        .clk(clk), .reset(reset),
        .lookup_v_i(lookup_v), .lookup_pc_i(lookup_pc),
        .pred_v_o(bi_pred_v), .pred_taken_o(bi_pred_taken),
        .pred_idx_o(bi_pred_idx), .pred_cnt_o(bi_pred_cnt),
        .update_v_i(update_v), .update_idx_i(update_idx),
        .update_taken_i(update_taken), .hist_o(bi_hist)
    );

    branch_predictor_table #(.GSHARE(0), .W_CNT(3)) u_b3 (
        .clk(clk), .reset(reset),
        .lookup_v_i(lookup_v), .lookup_pc_i(lookup_pc),
        .pred_v_o(b3_pred_v), .pred_taken_o(b3_pred_taken),
        .pred_idx_o(b3_pred_idx), .pred_cnt_o(b3_pred_cnt),
        .update_v_i(update_v), .update_idx_i(update_idx),
        .update_taken_i(update_taken), .hist_o(b3_hist)
    );

    typedef struct {
        int idx_g;
        int cnt_g;
        int idx_b;
        int cnt_b;
        int cnt_b3;
    } exp_t;

    int    assert_count = 0;
    int    fail_count = 0;
    int    m_g[64];
    int    m_b[64];
    int    m_b3[64];
    int    m_hist;
    exp_t  exp_q[$];
    exp_t  held_exp;
    bit    last_lookup;
    string last_tag = "init";

    // Count one comparison and report it when it does not hold.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int satNext(input int c, input bit taken, input int max_val);
        if (taken) return (c < max_val) ? c + 1 : c;
        return (c > 0) ? c - 1 : c;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 64; i++) begin
            m_g[i]  = 1;
            m_b[i]  = 1;
            m_b3[i] = 3;
        end
        m_hist = 0;
        exp_q.delete();
        held_exp = '{idx_g: 0, cnt_g: 1, idx_b: 0, cnt_b: 1, cnt_b3: 3};
        last_lookup = 1'b0;
    endtask

    // Compare every output of all three instances against one expectation.
    task automatic checkAll(input string tag, input exp_t e, input bit v);
        checkOutput({tag, "/gs_v"}, gs_pred_v, v);
        checkOutput({tag, "/gs_idx"}, gs_pred_idx, e.idx_g);
        checkOutput({tag, "/gs_cnt"}, gs_pred_cnt, e.cnt_g);
        checkOutput({tag, "/gs_tkn"}, gs_pred_taken, (e.cnt_g >> 1) & 1);
        checkOutput({tag, "/gs_hist"}, gs_hist, m_hist);
        checkOutput({tag, "/bi_v"}, bi_pred_v, v);
        checkOutput({tag, "/bi_idx"}, bi_pred_idx, e.idx_b);
        checkOutput({tag, "/bi_cnt"}, bi_pred_cnt, e.cnt_b);
        checkOutput({tag, "/bi_tkn"}, bi_pred_taken, (e.cnt_b >> 1) & 1);
        checkOutput({tag, "/bi_hist"}, bi_hist, 0);
        checkOutput({tag, "/b3_v"}, b3_pred_v, v);
        checkOutput({tag, "/b3_idx"}, b3_pred_idx, e.idx_b);
        checkOutput({tag, "/b3_cnt"}, b3_pred_cnt, e.cnt_b3);
        checkOutput({tag, "/b3_tkn"}, b3_pred_taken, (e.cnt_b3 >> 2) & 1);
        checkOutput({tag, "/b3_hist"}, b3_hist, 0);
    endtask

    // Check what the previous edge produced: a queued prediction if a lookup
    // was issued, otherwise held fields with valid low.
    task automatic monitorOutputs();
        if (last_lookup && exp_q.size() > 0) begin
            held_exp = exp_q.pop_front();
            checkAll(last_tag, held_exp, 1'b1);
        end else begin
            checkAll({last_tag, "_hold"}, held_exp, 1'b0);
        end
    endtask

    task automatic applyStimulus(input string tag, input bit lv, input logic [31:0] pc,
                                 input bit uv, input int uidx, input bit ut);
        exp_t e;
        int   pc_idx;
        @(negedge clk);
        monitorOutputs();
        lookup_v     = lv;
        lookup_pc    = pc;
        update_v     = uv;
        update_idx   = 6'(uidx);
        update_taken = ut;
        pc_idx  = int'((pc >> 2) & 32'h3f);
        e.idx_g = pc_idx ^ m_hist;
        e.idx_b = pc_idx;
        if (uv) begin
            m_g[uidx]  = satNext(m_g[uidx], ut, 3);
            m_b[uidx]  = satNext(m_b[uidx], ut, 3);
            m_b3[uidx] = satNext(m_b3[uidx], ut, 7);
            m_hist     = ((m_hist << 1) | int'(ut)) & 63;
        end
        if (lv) begin
            e.cnt_g  = m_g[e.idx_g];
            e.cnt_b  = m_b[e.idx_b];
            e.cnt_b3 = m_b3[e.idx_b];
            exp_q.push_back(e);
        end
        last_lookup = lv;
        last_tag    = tag;
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(tag, 1'b0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    // Assert reset wherever the clock is, check it took effect before any
    // edge, then release it just after a falling edge.
    task automatic resetDut(input string tag);
        reset    = 1'b0;
        lookup_v = 1'b0;
        update_v = 1'b0;
        #1;
        modelReset();
        checkAll({tag, "_rst"}, held_exp, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b1;
        last_tag = {tag, "_post"};
    endtask

    initial begin
        #1;
        resetDut("init");

        applyStimulus("t1_look", 1'b1, 32'h100, 1'b0, 0, 1'b0);
        idleCycle("t1_idle");

        resetDut("t2");
        for (int i = 0; i < 3; i++) applyStimulus("t2_upd", 1'b0, 32'h0, 1'b1, 5, 1'b1);
        applyStimulus("t2_look", 1'b1, 32'h14, 1'b0, 0, 1'b0);
        idleCycle("t2_idle");

        resetDut("t3");
        for (int i = 0; i < 2; i++) applyStimulus("t3_upd", 1'b0, 32'h0, 1'b1, 5, 1'b0);
        applyStimulus("t3_look", 1'b1, 32'h14, 1'b0, 0, 1'b0);
        idleCycle("t3_idle");

        resetDut("t4");
        applyStimulus("t4_bypass", 1'b1, 32'h14, 1'b1, 5, 1'b1);
        idleCycle("t4_idle");

        resetDut("t5");
        for (int i = 0; i < 3; i++) applyStimulus("t5_upd", 1'b0, 32'h0, 1'b1, 0, 1'b1);
        applyStimulus("t5_look", 1'b1, 32'h20, 1'b0, 0, 1'b0);
        idleCycle("t5_idle");

        resetDut("rnd");
        for (int i = 0; i < 80; i++) begin
            logic [31:0] pc;
            int          uidx;
            pc   = $urandom;
            uidx = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) uidx = int'((pc >> 2) & 32'h3f);
            applyStimulus("rnd", 1'($urandom_range(0, 1)), pc,
                          1'($urandom_range(0, 1)), uidx, 1'($urandom_range(0, 1)));
        end
        idleCycle("rnd_idle");

        resetDut("t6");
        for (int i = 0; i < 3; i++) applyStimulus("t6_upd", 1'b0, 32'h0, 1'b1, 9, 1'b1);
        applyStimulus("t6_look", 1'b1, 32'h24, 1'b0, 0, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("t6_pre_v", gs_pred_v, 1'b1);
        resetDut("t6_mid");
        applyStimulus("t6_after", 1'b1, 32'h24, 1'b0, 0, 1'b0);
        idleCycle("t6_idle");
        idleCycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
Parametrised table of saturating branch-direction counters; the multi-entry successor to the single 2-bit fetch-stage counter. Lookup by fetch PC, optionally XORed with a global history register (gshare), with a registered prediction one cycle later. A separate update port from execute trains the addressed counter and, in gshare mode, shifts the resolved outcome into the history. Lives in fetch/, beside the fetch PC register.

Parameters:
W_PC, 32, fetch PC width
W_CNT, 2, counter width (>=1); prediction = counter MSB
N_ENTRY, 64, table depth, power of two; W_IDX = log2(N_ENTRY)
W_HIST, 6, global history length (1..W_IDX)
GSHARE, 1, 1 = index = PC bits XOR history; 0 = pure bimodal, history held at 0

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
lookup_v_i  in  1  lookup request this cycle
lookup_pc_i  in  W_PC  fetch PC; PC[W_IDX+1:2] used
pred_v_o  out  1  prediction valid (registered lookup_v_i)
pred_taken_o  out  1  predicted direction
pred_idx_o  out  W_IDX  table index used; travels with the branch for update
pred_cnt_o  out  W_CNT  counter value read
update_v_i  in  1  resolved-branch update
update_idx_i  in  W_IDX  index returned from pred_idx_o
update_taken_i  in  1  actual outcome
hist_o  out  W_HIST  current global history (debug/checkpoint)

Behaviour:
- Reset (async, reset=0): every counter = 2^(W_CNT-1)-1 (weakly not-taken; 01 for W_CNT=2); history = 0; pred_v_o=0, pred_taken_o=0, pred_idx_o=0, pred_cnt_o=reset counter value. Takes effect immediately mid-operation; in-flight lookup dropped.
- Index: idx = PC[W_IDX+1:2] XOR zero-extended history when GSHARE=1, else PC[W_IDX+1:2].
- Lookup latency 1: lookup_v_i at edge t -> pred_v_o=1 and fields valid after edge t. pred_taken_o = MSB of pred_cnt_o. Output registers hold their last value when lookup_v_i=0; pred_v_o drops to 0.
- Lookup uses the history value present in its own cycle (pre-update).
- Update: at the edge with update_v_i=1, counter[update_idx_i] += 1 if update_taken_i and not all ones; -= 1 if !update_taken_i and not zero; otherwise unchanged (saturate both ends, no wrap). In gshare mode, history <= {history[W_HIST-2:0], update_taken_i} on the same edge (non-speculative history).
- Bypass: lookup and update to the same index in the same cycle -> pred_cnt_o/pred_taken_o reflect the post-update counter value.
- One update per cycle; back-to-back updates to the same index accumulate with no lost increments.
- No handshake stall: block always accepts lookup and update.

Decomposition:
- Shared params include: W_PC, W_CNT, N_ENTRY, W_HIST, derived W_IDX and counter reset constant; replaces the old fixed W_BRID width.
- One sub-module: sat_counter_next (combinational W_CNT saturating inc/dec, taken/not-taken in, next value out), used for the update path and the bypass path.

Test Plan:
1. Reset, then lookup pc=0x100 -> next cycle pred_v_o=1, pred_cnt_o=01, pred_taken_o=0; hist_o=0.
2. GSHARE=0: three updates taken, idx=5 -> counter 01,10,11,11 (saturates); lookup pc=0x14 -> pred_idx_o=5, pred_cnt_o=11, taken=1.
3. GSHARE=0 from reset: two updates not-taken, idx=5 -> 00, 00 (no wrap to 11); lookup pc=0x14 -> pred_cnt_o=00.
4. Bypass: from reset, update taken idx=5 and lookup pc=0x14 in the same cycle -> pred_cnt_o=10, pred_taken_o=1.
5. GSHARE=1: three taken updates to idx=0 -> hist_o=000111; lookup pc=0x20 (PC[7:2]=001000) -> pred_idx_o=001111 (15), pred_cnt_o=01.
6. Async reset asserted mid-cycle while pred_v_o=1 after training -> pred_v_o=0 and hist_o=0 before next edge; lookup of trained index after release -> pred_cnt_o=01; repeat with W_CNT=3 -> 011.
